// File: rtl/fifo_pop_packer.sv
// fifo_pop_packer
// Drains narrow entries from a push/pop FIFO and packs WORDS consecutive
// entries into one wide word, presented downstream on valid/ready.
//
// Ports:
//   clock      rising-edge clock, shared with the FIFO
//   reset_n    asynchronous active-low reset
//   fifoData   FIFO head entry (meaningful only while fifoEmpty=0)
//   fifoEmpty  FIFO empty flag
//   fifoPush   FIFO push line; a push inside the FIFO suppresses its pop
//   pop        pop request to the FIFO (combinational)
//   flush      emit the current partial word
//   outData    packed word, entry k at bits [(k+1)*(MSBD+1)-1 : k*(MSBD+1)]
//   outCount   number of valid entries in outData while outValid=1
//   outValid   packed word available
//   outReady   downstream accepts the word
//   wordsSent  saturating count of completed output handshakes
module fifo_pop_packer #(
    parameter int unsigned MSBD  = 3,
    parameter int unsigned WORDS = 4,
    parameter int unsigned MSBC  = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [MSBD:0]               fifoData,
    input  logic                        fifoEmpty,
    input  logic                        fifoPush,
    output logic                        pop,
    input  logic                        flush,
    output logic [(MSBD+1)*WORDS-1:0]   outData,
    output logic [MSBC:0]               outCount,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [7:0]                  wordsSent
);

    localparam int unsigned DW = MSBD + 1;
    localparam int unsigned CW = MSBC + 1;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [MSBC:0]   count_q;
    logic [MSBC:0]   count_next;
    logic            take;
    logic            enter_hold;
    logic            handshake;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a flush counts the entry popped in the same cycle
    always_comb begin
        state_d    = state_q;
        enter_hold = 1'b0;
        case (state_q)
            COLLECT: begin
                if ((take && (count_next == CW'(WORDS))) ||
                    (flush && (count_next != '0))) begin
                    state_d    = HOLD;
                    enter_hold = 1'b1;
                end
            end
            HOLD: begin
                if (handshake) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Output/control decode; the FIFO itself drops a pop when it sees a push
    always_comb begin
        pop        = 1'b0;
        take       = 1'b0;
        count_next = count_q;
        handshake  = 1'b0;
        if (state_q == COLLECT) begin
            pop = ~fifoEmpty;
        end
        take       = pop & ~fifoPush;
        count_next = count_q + CW'(take);
        handshake  = (state_q == HOLD) & outValid & outReady;
    end

    // Packing datapath; unused slots stay zero because the word is cleared on handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            outData   <= '0;
            outCount  <= '0;
            outValid  <= 1'b0;
            wordsSent <= '0;
        end else if (handshake) begin
            count_q  <= '0;
            outData  <= '0;
            outValid <= 1'b0;
            if (wordsSent != 8'hFF) begin
                wordsSent <= wordsSent + 8'd1;
            end
        end else begin
            if (take) begin
                for (int unsigned k = 0; k < WORDS; k++) begin
                    if (count_q == CW'(k)) begin
                        outData[k*DW +: DW] <= fifoData;
                    end
                end
                count_q <= count_next;
            end
            if (enter_hold) begin
                outValid <= 1'b1;
                outCount <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_fifo_pop_packer.sv
// Testbench for fifo_pop_packer: a queue-backed FIFO model feeds the DUT,
// directed scenarios check packing, push blocking, flush, backpressure,
// wordsSent saturation and asynchronous reset.
module tb_fifo_pop_packer;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic [3:0]  fifoData  = 4'h0;
    logic        fifoEmpty = 1'b1;
    logic        fifoPush  = 1'b0;
    logic        flush     = 1'b0;
    logic        outReady  = 1'b0;
    logic        pop;
    logic [15:0] outData;
    logic [2:0]  outCount;
    logic        outValid;
    logic [7:0]  wordsSent;

    int checks    = 0;
    int errors    = 0;
    int taken_cnt = 0;
    int pop_cyc   = 0;
    int exp_sent  = 0;
    logic [3:0] q[$];

    always #5 clock = ~clock;

    fifo_pop_packer #(.MSBD(3), .WORDS(4), .MSBC(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .fifoData  (fifoData),
        .fifoEmpty (fifoEmpty),
        .fifoPush  (fifoPush),
        .pop       (pop),
        .flush     (flush),
        .outData   (outData),
        .outCount  (outCount),
        .outValid  (outValid),
        .outReady  (outReady),
        .wordsSent (wordsSent)
    );

    function automatic void refresh();
        fifoEmpty = (q.size() == 0);
        fifoData  = (q.size() != 0) ? q[0] : 4'h0;
    endfunction

    // FIFO model: consumes the head on a pop not blocked by a push
    initial begin
        forever begin
            @(posedge clock);
            if (pop) pop_cyc++;
            if (pop && !fifoPush && q.size() > 0) begin
                void'(q.pop_front());
                taken_cnt++;
            end
            #1 refresh();
            @(negedge clock);
            refresh();
        end
    end

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clock); #2;
            if (outValid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #2;
            checks++; if (pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", pop); end
            checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", outValid); end
            checks++; if (outData !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", outData); end
            checks++; if (wordsSent !== 8'd0) begin errors++; $display("FAIL reset_sent: got %0d expected 0", wordsSent); end
        end
    endtask

    task automatic test_full_word();
        bit ok;
        int t0, p0;
        @(posedge clock); #2;
        outReady = 1'b1;
        t0 = taken_cnt; p0 = pop_cyc;
        for (int i = 1; i <= 4; i++) q.push_back(4'(i));
        wait_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout: got no outValid expected outValid=1"); end
        checks++; if (outData !== 16'h4321) begin errors++; $display("FAIL full_data: got %h expected 4321", outData); end
        checks++; if (outCount !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", outCount); end
        checks++; if (pop_cyc - p0 != 4) begin errors++; $display("FAIL full_popcyc: got %0d expected 4", pop_cyc - p0); end
        checks++; if (taken_cnt - t0 != 4) begin errors++; $display("FAIL full_taken: got %0d expected 4", taken_cnt - t0); end
        @(posedge clock); #2;
        exp_sent++;
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL full_hs_valid: got %b expected 0", outValid); end
        checks++; if (wordsSent !== 8'(exp_sent)) begin errors++; $display("FAIL full_sent: got %0d expected %0d", wordsSent, exp_sent); end
    endtask

    task automatic test_push_block();
        bit ok;
        int t0, p0;
        @(posedge clock); #2;
        outReady = 1'b1;
        t0 = taken_cnt; p0 = pop_cyc;
        for (int i = 1; i <= 4; i++) q.push_back(4'(i));
        @(posedge clock); #2 fifoPush = 1'b1;
        @(posedge clock); #2 fifoPush = 1'b0;
        wait_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL push_timeout: got no outValid expected outValid=1"); end
        checks++; if (outData !== 16'h4321) begin errors++; $display("FAIL push_data: got %h expected 4321", outData); end
        checks++; if (pop_cyc - p0 != 5) begin errors++; $display("FAIL push_popcyc: got %0d expected 5", pop_cyc - p0); end
        checks++; if (taken_cnt - t0 != 4) begin errors++; $display("FAIL push_taken: got %0d expected 4", taken_cnt - t0); end
        @(posedge clock); #2;
        exp_sent++;
        checks++; if (wordsSent !== 8'(exp_sent)) begin errors++; $display("FAIL push_sent: got %0d expected %0d", wordsSent, exp_sent); end
    endtask

    task automatic test_flush();
        bit ok;
        outReady = 1'b0;
        q.push_back(4'h5); q.push_back(4'h6);
        repeat (4) @(posedge clock);
        #2;
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_prevalid: got %b expected 0", outValid); end
        flush = 1'b1;
        wait_valid(4, ok);
        flush = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL flush_timeout: got no outValid expected outValid=1"); end
        checks++; if (outData !== 16'h0065) begin errors++; $display("FAIL flush_data: got %h expected 0065", outData); end
        checks++; if (outCount !== 3'd2) begin errors++; $display("FAIL flush_count: got %0d expected 2", outCount); end
        outReady = 1'b1;
        @(posedge clock); #2;
        exp_sent++;
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_hs_valid: got %b expected 0", outValid); end
        checks++; if (wordsSent !== 8'(exp_sent)) begin errors++; $display("FAIL flush_sent: got %0d expected %0d", wordsSent, exp_sent); end
        // flush with nothing collected is ignored
        outReady = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #2;
            checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_empty_valid: got %b expected 0", outValid); end
        end
        flush = 1'b0;
        // flush in the same cycle as the first taken pop includes that entry
        q.push_back(4'h7);
        flush = 1'b1;
        wait_valid(3, ok);
        flush = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL flushpop_timeout: got no outValid expected outValid=1"); end
        checks++; if (outData !== 16'h0007) begin errors++; $display("FAIL flushpop_data: got %h expected 0007", outData); end
        checks++; if (outCount !== 3'd1) begin errors++; $display("FAIL flushpop_count: got %0d expected 1", outCount); end
        outReady = 1'b1;
        @(posedge clock); #2;
        exp_sent++;
        checks++; if (wordsSent !== 8'(exp_sent)) begin errors++; $display("FAIL flushpop_sent: got %0d expected %0d", wordsSent, exp_sent); end
    endtask

    task automatic test_backpressure();
        bit ok;
        outReady = 1'b0;
        q.push_back(4'h8); q.push_back(4'h9); q.push_back(4'hA);
        q.push_back(4'hB); q.push_back(4'hC);
        wait_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no outValid expected outValid=1"); end
        checks++; if (outData !== 16'hBA98) begin errors++; $display("FAIL bp_data: got %h expected ba98", outData); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #2;
            checks++; if (pop !== 1'b0) begin errors++; $display("FAIL bp_pop: got %b expected 0", pop); end
            checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", outValid); end
            checks++; if (outData !== 16'hBA98) begin errors++; $display("FAIL bp_hold_data: got %h expected ba98", outData); end
        end
        outReady = 1'b1;
        @(posedge clock); #2;
        exp_sent++;
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL bp_hs_valid: got %b expected 0", outValid); end
        checks++; if (pop !== 1'b1) begin errors++; $display("FAIL bp_repop: got %b expected 1", pop); end
        checks++; if (wordsSent !== 8'(exp_sent)) begin errors++; $display("FAIL bp_sent: got %0d expected %0d", wordsSent, exp_sent); end
        // the leftover entry is popped while flush is high
        outReady = 1'b0;
        flush = 1'b1;
        wait_valid(4, ok);
        flush = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL bp_tail_timeout: got no outValid expected outValid=1"); end
        checks++; if (outData !== 16'h000C) begin errors++; $display("FAIL bp_tail_data: got %h expected 000c", outData); end
        checks++; if (outCount !== 3'd1) begin errors++; $display("FAIL bp_tail_count: got %0d expected 1", outCount); end
        outReady = 1'b1;
        @(posedge clock); #2;
        exp_sent++;
        checks++; if (wordsSent !== 8'(exp_sent)) begin errors++; $display("FAIL bp_tail_sent: got %0d expected %0d", wordsSent, exp_sent); end
    endtask

    task automatic test_saturation();
        bit done;
        outReady = 1'b1;
        for (int i = 0; i < 1024; i++) q.push_back(4'(i));
        done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #2;
            if (q.size() == 0 && !outValid) begin
                done = 1'b1;
                break;
            end
        end
        exp_sent = exp_sent + 256;
        if (exp_sent > 255) exp_sent = 255;
        checks++; if (!done) begin errors++; $display("FAIL sat_timeout: got %0d entries left expected 0", q.size()); end
        checks++; if (wordsSent !== 8'(exp_sent)) begin errors++; $display("FAIL sat_sent: got %0d expected %0d", wordsSent, exp_sent); end
    endtask

    task automatic test_async_reset();
        outReady = 1'b0;
        q.push_back(4'h1); q.push_back(4'h2);
        repeat (4) @(posedge clock);
        #2;
        checks++; if (dut.count_q !== 3'd2) begin errors++; $display("FAIL ar_pre_count: got %0d expected 2", dut.count_q); end
        checks++; if (outData !== 16'h0021) begin errors++; $display("FAIL ar_pre_data: got %h expected 0021", outData); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL ar_count: got %0d expected 0", dut.count_q); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", outValid); end
        checks++; if (wordsSent !== 8'd0) begin errors++; $display("FAIL ar_sent: got %0d expected 0", wordsSent); end
        checks++; if (outData !== 16'h0000) begin errors++; $display("FAIL ar_data: got %h expected 0000", outData); end
        @(posedge clock); #2 reset_n = 1'b1;
        @(posedge clock); #2;
        checks++; if (pop !== 1'b0) begin errors++; $display("FAIL ar_post_pop: got %b expected 0", pop); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL ar_post_valid: got %b expected 0", outValid); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_push_block();
        test_flush();
        test_backpressure();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
